// File: rtl/alu_defs.sv
// alu_defs: shared ALU op codes, RV32I opcode and funct constants
package alu_defs;
  typedef enum logic [3:0] {
    ALU_NONE = 4'h0,
    ALU_ADD  = 4'h1,
    ALU_SUB  = 4'h2,
    ALU_XOR  = 4'h3,
    ALU_OR   = 4'h4,
    ALU_AND  = 4'h5,
    ALU_SLL  = 4'h6,
    ALU_SRL  = 4'h7,
    ALU_SRA  = 4'h8,
    ALU_SLT  = 4'h9,
    ALU_SLTU = 4'hA
  } alu_op_e;
  localparam logic [6:0] OP_R      = 7'b0110011;
  localparam logic [6:0] OP_I      = 7'b0010011;
  localparam logic [6:0] OP_LUI    = 7'b0110111;
  localparam logic [6:0] OP_AUIPC  = 7'b0010111;
  localparam logic [6:0] OP_BRANCH = 7'b1100011;
  localparam logic [6:0] OP_LOAD   = 7'b0000011;
  localparam logic [6:0] OP_STORE  = 7'b0100011;
  localparam logic [6:0] OP_JAL    = 7'b1101111;
  localparam logic [6:0] OP_JALR   = 7'b1100111;
  localparam logic [2:0] F3_ADD  = 3'b000;
  localparam logic [2:0] F3_SLL  = 3'b001;
  localparam logic [2:0] F3_SLT  = 3'b010;
  localparam logic [2:0] F3_SLTU = 3'b011;
  localparam logic [2:0] F3_XOR  = 3'b100;
  localparam logic [2:0] F3_SR   = 3'b101;
  localparam logic [2:0] F3_OR   = 3'b110;
  localparam logic [6:0] F7_BASE = 7'b0000000;
  localparam logic [6:0] F7_ALT  = 7'b0100000;
  function automatic alu_op_e alu_of(input logic [2:0] f3, input logic alt);
    alu_of = ALU_AND;
    case (f3)
      F3_ADD:  alu_of = alt ? ALU_SUB : ALU_ADD;
      F3_SLL:  alu_of = ALU_SLL;
      F3_SLT:  alu_of = ALU_SLT;
      F3_SLTU: alu_of = ALU_SLTU;
      F3_XOR:  alu_of = ALU_XOR;
      F3_SR:   alu_of = alt ? ALU_SRA : ALU_SRL;
      F3_OR:   alu_of = ALU_OR;
      default: alu_of = ALU_AND;
    endcase
  endfunction
endpackage

// File: rtl/imm_gen.sv
// imm_gen: I/S/U immediate extraction and sign extension selected by opcode
module imm_gen
  import alu_defs::*;
#(
  parameter int WORD_SIZE = 32
) (
  input  logic [31:0]          instr,
  output logic [WORD_SIZE-1:0] imm
);
  logic [6:0]  op;
  logic [31:0] raw;
  assign op = instr[6:0];
  // stores split their offset; LUI/AUIPC take the upper 20 bits; everything else is I-form
  always_comb begin
    raw = (op == OP_STORE) ? {{20{instr[31]}}, instr[31:25], instr[11:7]} :
          (op == OP_LUI || op == OP_AUIPC) ? {instr[31:12], 12'b0} :
          {{20{instr[31]}}, instr[31:20]};
  end
  assign imm = WORD_SIZE'($signed(raw));
endmodule

// File: rtl/alu_decode_stage.sv
// alu_decode_stage: registered RV32I decode producing ALU operands and op select
module alu_decode_stage
  import alu_defs::*;
#(
  parameter int WORD_SIZE = 32
) (
  input  logic                 clk,
  input  logic                 rst_n,
  input  logic                 in_valid,
  output logic                 in_ready,
  input  logic [31:0]          instr,
  input  logic [WORD_SIZE-1:0] pc,
  input  logic [WORD_SIZE-1:0] rs1_data,
  input  logic [WORD_SIZE-1:0] rs2_data,
  input  logic                 flush,
  output logic                 out_valid,
  input  logic                 out_ready,
  output logic [3:0]           alu_sel,
  output logic [WORD_SIZE-1:0] arg_a,
  output logic [WORD_SIZE-1:0] arg_b,
  output logic [2:0]           br_type,
  output logic                 is_branch,
  output logic                 illegal
);
  logic [6:0]           opcode;
  logic [2:0]           f3;
  logic [6:0]           f7;
  logic [WORD_SIZE-1:0] imm;
  alu_op_e              d_sel;
  logic [WORD_SIZE-1:0] d_a;
  logic [WORD_SIZE-1:0] d_b;
  logic [2:0]           d_br;
  logic                 d_isb;
  logic                 d_ill;
  logic                 accept;
  assign opcode   = instr[6:0];
  assign f3       = instr[14:12];
  assign f7       = instr[31:25];
  assign in_ready = !out_valid || out_ready;
  assign accept   = in_valid && in_ready;
  imm_gen #(.WORD_SIZE(WORD_SIZE)) u_imm (
    .instr(instr),
    .imm  (imm)
  );
  // decode the incoming instruction; illegal encodings collapse to an all-zero bundle
  always_comb begin
    d_sel = ALU_NONE;
    d_a   = '0;
    d_b   = '0;
    d_br  = '0;
    d_isb = 1'b0;
    d_ill = 1'b0;
    case (opcode)
      OP_R: begin
        d_a   = rs1_data;
        d_b   = rs2_data;
        d_sel = alu_of(f3, f7 == F7_ALT);
        d_ill = !(f7 == F7_BASE || (f7 == F7_ALT && (f3 == F3_ADD || f3 == F3_SR)));
      end
      OP_I: begin
        d_a   = rs1_data;
        d_b   = imm;
        d_sel = alu_of(f3, f3 == F3_SR && f7 == F7_ALT);
        d_ill = (f3 == F3_SLL && f7 != F7_BASE) ||
                (f3 == F3_SR && f7 != F7_BASE && f7 != F7_ALT);
      end
      OP_LUI: begin
        d_sel = ALU_ADD;
        d_b   = imm;
      end
      OP_AUIPC: begin
        d_sel = ALU_ADD;
        d_a   = pc;
        d_b   = imm;
      end
      OP_BRANCH: begin
        d_a   = rs1_data;
        d_b   = rs2_data;
        d_isb = 1'b1;
        d_br  = f3;
        d_sel = f3[2] ? (f3[1] ? ALU_SLTU : ALU_SLT) : ALU_SUB;
        d_ill = f3[2:1] == 2'b01;
      end
      OP_LOAD, OP_STORE: begin
        d_sel = ALU_ADD;
        d_a   = rs1_data;
        d_b   = imm;
      end
      OP_JAL, OP_JALR: begin
        d_sel = ALU_ADD;
        d_a   = pc;
        d_b   = WORD_SIZE'(4);
      end
      default: d_ill = 1'b1;
    endcase
    if (d_ill) begin
      d_sel = ALU_NONE;
      d_a   = '0;
      d_b   = '0;
      d_br  = '0;
      d_isb = 1'b0;
    end
  end
  // output register: flush wins, then accept, then drain; data holds otherwise
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      out_valid <= 1'b0;
      alu_sel   <= '0;
      arg_a     <= '0;
      arg_b     <= '0;
      br_type   <= '0;
      is_branch <= 1'b0;
      illegal   <= 1'b0;
    end else if (flush) begin
      out_valid <= 1'b0;
    end else if (accept) begin
      out_valid <= 1'b1;
      alu_sel   <= d_sel;
      arg_a     <= d_a;
      arg_b     <= d_b;
      br_type   <= d_br;
      is_branch <= d_isb;
      illegal   <= d_ill;
    end else if (out_ready) begin
      out_valid <= 1'b0;
    end
  end
endmodule

// File: doc/alu_decode_stage.md
Name: alu_decode_stage

Overview:
- Pipeline stage that produces the ALU's operands and operation select.
- Decodes a 32-bit RV32I instruction, picks arg_a/arg_b from register data, PC or immediate, and emits the 4-bit ALU select code, with branch and illegal-instruction side info.
- One registered stage between fetch/regfile read and execute, with valid/ready handshakes on both sides and a flush input for taken branches.

Parameters:
- WORD_SIZE, 32, datapath width of PC, register data and operands.

Ports:
- clk  input  1  rising-edge clock
- rst_n  input  1  asynchronous active-low reset
- in_valid  input  1  upstream holds a valid instruction
- in_ready  output  1  stage can accept this cycle
- instr  input  32  instruction word
- pc  input  WORD_SIZE  instruction address
- rs1_data  input  WORD_SIZE  register-file read port 1
- rs2_data  input  WORD_SIZE  register-file read port 2
- flush  input  1  discard held and incoming instruction
- out_valid  output  1  decoded bundle valid
- out_ready  input  1  execute stage accepts bundle
- alu_sel  output  4  ALU op code: ADD=1, SUB=2, XOR=3, OR=4, AND=5, SLL=6, SRL=7, SRA=8, SLT=9, SLTU=A, 0=none
- arg_a  output  WORD_SIZE  ALU operand A
- arg_b  output  WORD_SIZE  ALU operand B
- br_type  output  3  funct3 of branch, valid when is_branch
- is_branch  output  1  bundle is a conditional branch
- illegal  output  1  unsupported or malformed encoding

Behaviour:
- Reset (async, rst_n=0): out_valid=0; alu_sel, arg_a, arg_b, br_type=0; is_branch=0; illegal=0. in_ready=1 once out_valid=0.
- Handshake: in_ready = !out_valid || out_ready (combinational).
- Accept when in_valid && in_ready: latch the decoded bundle and set out_valid=1 the next cycle. Latency is exactly 1 cycle.
- If out_valid && out_ready && !(in_valid && in_ready), out_valid clears.
- Back-to-back accept with out_ready=1 gives 1 bundle per cycle.
- Stall: while out_valid && !out_ready, all outputs hold stable and in_ready=0.
- Flush (priority over everything): next cycle out_valid=0, and any input accepted in the flush cycle is dropped. in_ready still follows its formula during flush, so upstream sees its instruction as consumed.
- Decode by opcode instr[6:0]:
  - 0110011 R-type: arg_a=rs1, arg_b=rs2.
    - funct3 000: ADD, or SUB when funct7=0100000.
    - 001 SLL; 010 SLT; 011 SLTU; 100 XOR.
    - 101: SRL, or SRA when funct7=0100000.
    - 110 OR; 111 AND.
    - funct7 other than 0000000/0100000, or 0100000 with funct3 not 000/101: illegal.
  - 0010011 I-type: arg_a=rs1, arg_b=sign-extended instr[31:20]. Same funct3 map, no SUB.
    - SLLI requires instr[31:25]=0000000.
    - SRLI/SRAI: instr[31:25]=0000000 gives SRL, 0100000 gives SRA.
    - Any other upper bits: illegal.
  - 0110111 LUI: ADD, arg_a=0, arg_b={instr[31:12],12'b0}.
  - 0010111 AUIPC: ADD, arg_a=pc, arg_b={instr[31:12],12'b0}.
  - 1100011 branch: arg_a=rs1, arg_b=rs2, is_branch=1, br_type=funct3.
    - BEQ/BNE (000/001): SUB.
    - BLT/BGE (100/101): SLT.
    - BLTU/BGEU (110/111): SLTU.
    - 010/011: illegal.
  - 0000011 load / 0100011 store: ADD, arg_a=rs1, arg_b=sign-extended I/S immediate.
  - 1101111 JAL / 1100111 JALR: ADD, arg_a=pc, arg_b=4 (link value).
  - Any other opcode: illegal.
- When illegal=1: alu_sel=0, arg_a=0, arg_b=0, is_branch=0. out_valid still asserts so the trap is seen downstream.
- Immediates are sign-extended to WORD_SIZE from instr[31].

Decomposition:
- Shared package alu_defs: ALU op localparams (ADD..SLTU codes), opcode constants, funct3/funct7 constants. The ALU and this stage both use it.
- Sub-module imm_gen: combinational I/S/U immediate extraction, selected by opcode.
- Decode logic is combinational; the output register and handshake live in the top module.

Test Plan:
- Reset mid-stall: out_valid=1, out_ready=0, assert rst_n=0 -> out_valid=0 immediately, all outputs 0, in_ready=1.
- R-type SUB: instr=0x40208033 (sub x0,x1,x2), rs1=7, rs2=3 -> next cycle out_valid=1, alu_sel=2, arg_a=7, arg_b=3, illegal=0.
- ADDI negative: instr=0xFFF08093 (addi x1,x1,-1), rs1=5 -> alu_sel=1, arg_b=0xFFFFFFFF. Then SRAI instr=0x4030D093 -> alu_sel=8, arg_b[4:0]=3.
- BLTU: instr=0x0020E463, rs1=1, rs2=2 -> alu_sel=A, is_branch=1, br_type=6. Then AUIPC 0x00001117 with pc=0x100 -> arg_a=0x100, arg_b=0x1000, alu_sel=1.
- Backpressure: 3 instructions streamed, out_ready=0 for 2 cycles after first -> in_ready=0, outputs frozen. Then all 3 emerge in order, none lost or duplicated.
- Flush/illegal: flush with in_valid=1 -> next cycle out_valid=0. M-ext instr=0x02208033 -> illegal=1, alu_sel=0, out_valid=1.
